// File: rtl/stat_seg_display.sv
// rtl/stat_seg_display.sv - MA-stage event counters with a multiplexed 8-digit hex display
// Counts pipeline events while the CPU runs and scans the selected 32-bit view onto 7-seg digits.
module stat_seg_display #(
  parameter int CntBits = 32,
  parameter int ScanDiv = 100000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic        i_halt,
  input  logic        i_is_jump,
  input  logic        i_is_branch,
  input  logic        i_branched,
  input  logic        i_is_nop,
  input  logic [31:0] i_display,
  input  logic [2:0]  i_sel,
  output logic [7:0]  o_seg_an,
  output logic [7:0]  o_seg_ca,
  output logic        o_halted
);

  localparam int PreW = $clog2(ScanDiv);

  logic [CntBits-1:0] r_cyc, r_jmp, r_br, r_tkn, r_nop;
  logic               r_halted;
  logic [31:0]        r_view;
  logic [PreW-1:0]    r_pre;
  logic [2:0]         r_idx;

  logic               w_run;
  logic [CntBits-1:0] w_diff;
  logic [31:0]        w_view;
  logic [3:0]         w_nib;

  // The halt cycle itself must not count, so halt gates run combinationally.
  assign w_run  = i_en & ~i_halt & ~r_halted;
  assign w_diff = r_cyc - r_nop;
  assign w_nib  = r_view[{r_idx, 2'b00} +: 4];

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    case (n)
      4'h0: hex_font = 7'h40;
      4'h1: hex_font = 7'h79;
      4'h2: hex_font = 7'h24;
      4'h3: hex_font = 7'h30;
      4'h4: hex_font = 7'h19;
      4'h5: hex_font = 7'h12;
      4'h6: hex_font = 7'h02;
      4'h7: hex_font = 7'h78;
      4'h8: hex_font = 7'h00;
      4'h9: hex_font = 7'h10;
      4'hA: hex_font = 7'h08;
      4'hB: hex_font = 7'h03;
      4'hC: hex_font = 7'h46;
      4'hD: hex_font = 7'h21;
      4'hE: hex_font = 7'h06;
      default: hex_font = 7'h0E;
    endcase
  endfunction

  always_comb begin
    w_view = 32'h0;
    case (i_sel)
      3'd0: w_view = i_display;
      3'd1: w_view = 32'(r_cyc);
      3'd2: w_view = 32'(r_jmp);
      3'd3: w_view = 32'(r_br);
      3'd4: w_view = 32'(r_tkn);
      3'd5: w_view = 32'(r_nop);
      3'd6: w_view = 32'(w_diff);
      default: w_view = 32'h0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cyc    <= '0;
      r_jmp    <= '0;
      r_br     <= '0;
      r_tkn    <= '0;
      r_nop    <= '0;
      r_halted <= 1'b0;
    end else begin
      if (i_en & i_halt) r_halted <= 1'b1;
      if (w_run) begin
        r_cyc <= r_cyc + 1'b1;
        if (i_is_jump)                r_jmp <= r_jmp + 1'b1;
        if (i_is_branch)              r_br  <= r_br + 1'b1;
        if (i_is_branch & i_branched) r_tkn <= r_tkn + 1'b1;
        if (i_is_nop)                 r_nop <= r_nop + 1'b1;
      end
    end
  end

  // Scan runs regardless of en/halt so the display stays live while stopped.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_view   <= 32'h0;
      r_pre    <= '0;
      r_idx    <= 3'd0;
      o_seg_an <= 8'hFE;
      o_seg_ca <= 8'hC0;
    end else begin
      r_view <= w_view;
      if (r_pre == PreW'(ScanDiv - 1)) begin
        r_pre <= '0;
        r_idx <= r_idx + 3'd1;
      end else begin
        r_pre <= r_pre + PreW'(1);
      end
      o_seg_an <= ~(8'd1 << r_idx);
      o_seg_ca <= {~(r_halted & (r_idx == 3'd0)), hex_font(w_nib)};
    end
  end

  assign o_halted = r_halted;

endmodule
